sram_access_controller: RTL

- Multi-cycle sequencer between the MEM stage and the external 16-bit SRAM that backs data memory.
- Converts one 32-bit LDR/STR request into two half-word SRAM accesses, each WAIT_CYCLES long.
- Holds the pipeline via `ready` until the access completes.
- Driven by the mem_read/mem_write controls produced in decode and carried down the pipeline.

---
 rtl/sram_access_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_access_controller
//  Description : Splits a 32-bit MEM-stage load/store into two half-word
//                accesses on a 16-bit external SRAM. Each half-word access
//                lasts WAIT_CYCLES cycles. ready stalls the pipeline until
//                the word transfer is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_access_controller #(
    parameter int          WAIT_CYCLES = 3,
    parameter int          ADDR_WIDTH  = 18,
    parameter logic [31:0] MEM_BASE    = 32'd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [15:0]           sram_dq_out,
    input  logic [15:0]           sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_we_n
);

    localparam int                 c_CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-2:0] r_word;
    logic [31:0]           r_wdata;
    logic                  r_op_wr;
    logic [31:0]           r_read_data;

    logic                  w_req;
    logic                  w_last;
    logic [31:0]           w_offset;
    logic                  w_unused_offset_bits;

    assign w_req    = rd_en | wr_en;
    assign w_last   = (r_cnt == c_CNT_LAST);
    // Offset into data memory; wraps modulo 2^32 for addresses below MEM_BASE.
    assign w_offset = address - MEM_BASE;
    // Byte-lane bits and word bits beyond the SRAM are deliberately dropped.
    assign w_unused_offset_bits = ^{w_offset[31:ADDR_WIDTH+1], w_offset[1:0]};

    assign read_data = r_read_data;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase counter: restarts on every state change, counts within LOW/HIGH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_cnt <= '0;
        end else if (r_state == S_LOW || r_state == S_HIGH) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Request latch: the controller works only from these copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word  <= '0;
            r_wdata <= '0;
            r_op_wr <= 1'b0;
        end else if (r_state == S_IDLE && w_req) begin
            r_word  <= w_offset[ADDR_WIDTH:2];
            r_wdata <= write_data;
            r_op_wr <= wr_en;
        end
    end

    // Read capture at the last cycle of each half-word phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data <= '0;
        end else if (!r_op_wr && w_last) begin
            if (r_state == S_LOW) begin
                r_read_data[15:0] <= sram_dq_in;
            end else if (r_state == S_HIGH) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Next-state, SRAM pin drive and pipeline handshake.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        sram_addr    = '0;
        sram_dq_out  = '0;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                sram_addr = {r_word, 1'b0};
                if (r_op_wr) begin
                    sram_dq_out = r_wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (w_last) begin
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                sram_addr = {r_word, 1'b1};
                if (r_op_wr) begin
                    sram_dq_out = r_wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Requests here belong to the instruction being released.
                ready        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
